// File: rtl/adder_operand_loader_if.sv
// Word-stream interface feeding adder_operand_loader.
// A word transfers on every rising clk edge where in_valid && in_ready; in_data is don't-care otherwise.
interface adder_operand_loader_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/adder_operand_loader.sv
// Assembles two OP_W-bit operands from a 32-bit word stream and hands them to the adder controller.
// Optional macro OPERAND_PAD_CHECK_EN adds pad_err, flagging non-zero padding bits in each operand's last word.
module adder_operand_loader #(
    parameter int WORD_W    = 32,
    parameter int OP_W      = 381,
    parameter int NUM_WORDS = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    adder_operand_loader_if.slave        in_if,
    input  logic                         adder_done,
    output logic                         start,
    output logic [OP_W-1:0]              op_a,
    output logic [OP_W-1:0]              op_b,
    output logic                         busy,
`ifdef OPERAND_PAD_CHECK_EN
    output logic                         pad_err,
`endif
    output logic [1:0]                   state_dbg,
    output logic [$clog2(NUM_WORDS)-1:0] count_dbg
);
    localparam int CNT_W  = $clog2(NUM_WORDS);
    localparam int PAD_W  = NUM_WORDS * WORD_W - OP_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, FIRE = 2'd2, WAIT_DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_d;
    logic [OP_W-1:0]   op_a_d, op_b_d;
    logic [OP_W-1:0]   wr_mask, wr_data;
    logic              accept, last_word;
`ifdef OPERAND_PAD_CHECK_EN
    logic              pad_err_d;
`endif

    assign in_if.in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign start          = (state_q == FIRE) || (state_q == WAIT_DONE);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign last_word      = (count_q == LAST);
    assign state_dbg      = state_q;
    assign count_dbg      = count_q;

    // Bits of the last word above OP_W fall off the top of the shift.
    assign wr_mask = OP_W'({WORD_W{1'b1}}) << (int'(count_q) * WORD_W);
    assign wr_data = OP_W'(in_if.in_data) << (int'(count_q) * WORD_W);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy_d  = busy;
        op_a_d  = op_a;
        op_b_d  = op_b;
`ifdef OPERAND_PAD_CHECK_EN
        pad_err_d = pad_err;
        if (accept && last_word && (in_if.in_data[WORD_W-1 -: PAD_W] != '0))
            pad_err_d = 1'b1;
`endif
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    op_a_d = (op_a & ~wr_mask) | wr_data;
                    busy_d = 1'b1;
                    if (last_word) begin
                        count_d = '0;
                        state_d = LOAD_B;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    op_b_d = (op_b & ~wr_mask) | wr_data;
                    busy_d = 1'b1;
                    if (last_word) begin
                        count_d = '0;
                        state_d = FIRE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            FIRE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (adder_done) begin
                    busy_d  = 1'b0;
                    count_d = '0;
                    state_d = LOAD_A;
`ifdef OPERAND_PAD_CHECK_EN
                    pad_err_d = 1'b0;
`endif
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_A;
            count_q <= '0;
            busy    <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
`ifdef OPERAND_PAD_CHECK_EN
            pad_err <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy    <= busy_d;
            op_a    <= op_a_d;
            op_b    <= op_b_d;
`ifdef OPERAND_PAD_CHECK_EN
            pad_err <= pad_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader: reset, packing, handshake gaps, WAIT freeze and done release.
module tb_adder_operand_loader;
    localparam logic [1:0] S_LOAD_A = 2'd0, S_LOAD_B = 2'd1, S_FIRE = 2'd2, S_WAIT = 2'd3;

    logic         clk = 1'b0;
    logic         reset;
    logic         adder_done;
    logic         start, busy;
    logic [380:0] op_a, op_b;
    logic [1:0]   state_dbg;
    logic [3:0]   count_dbg;
`ifdef OPERAND_PAD_CHECK_EN
    logic         pad_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0]  wa[12], wb[12];
    logic [380:0] exp_a, exp_b, ones, held_a, held_b;

    adder_operand_loader_if #(.WORD_W(32)) in_if ();

    adder_operand_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (in_if),
        .adder_done (adder_done),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
`ifdef OPERAND_PAD_CHECK_EN
        .pad_err    (pad_err),
`endif
        .state_dbg  (state_dbg),
        .count_dbg  (count_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_if.in_valid = 1'b1;
        in_if.in_data  = d;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_if.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [380:0] pack(input logic [31:0] w[12]);
        logic [383:0] t;
        for (int k = 0; k < 12; k++) t[k*32 +: 32] = w[k];
        return t[380:0];
    endfunction

    initial begin
        reset          = 1'b1;
        adder_done     = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        ones           = '1;

        // Reset values
        do_reset();
        chk("rst_in_ready", in_if.in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_state", state_dbg, S_LOAD_A);
        chk("rst_count", count_dbg, 0);
`ifdef OPERAND_PAD_CHECK_EN
        chk("rst_pad_err", pad_err, 0);
`endif

        // Reset during LOAD_B after 5 words
        for (int k = 0; k < 12; k++) send(32'h1234_5678 + k);
        for (int k = 0; k < 5; k++) send(32'h0BAD_0000 + k);
        in_if.in_valid = 1'b0;
        chk("midb_state", state_dbg, S_LOAD_B);
        chk("midb_count", count_dbg, 5);
        chk("midb_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", state_dbg, S_LOAD_A);
        chk("midrst_count", count_dbg, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_op_b", op_b, 0);
        chk("midrst_op_a", op_a, 0);

        // All-ones A, B = 1, valid held high
        for (int k = 0; k < 12; k++) send(32'hFFFF_FFFF);
        chk("ab_switch_state", state_dbg, S_LOAD_B);
        chk("ab_switch_count", count_dbg, 0);
        send(32'h0000_0001);
        for (int k = 1; k < 11; k++) send(32'h0);
        chk("w23_start", start, 0);
        chk("w23_ready", in_if.in_ready, 1);
        send(32'h0);
        chk("fire_start", start, 1);
        chk("fire_ready", in_if.in_ready, 0);
        chk("fire_state", state_dbg, S_FIRE);
        chk("fire_busy", busy, 1);
        chk("ones_op_a", op_a, ones);
        chk("one_op_b", op_b, 381'd1);

        // Garbage in WAIT is ignored, then done releases
        for (int k = 0; k < 10; k++) send(32'hDEAD_0000 | k);
        chk("wait_state", state_dbg, S_WAIT);
        chk("wait_start", start, 1);
        chk("wait_op_a", op_a, ones);
        chk("wait_op_b", op_b, 381'd1);
        in_if.in_valid = 1'b0;
        adder_done = 1'b1;
        tick();
        adder_done = 1'b0;
        chk("done_start", start, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", in_if.in_ready, 1);
        chk("done_state", state_dbg, S_LOAD_A);
        chk("done_count", count_dbg, 0);
        chk("done_op_a", op_a, ones);
        chk("done_op_b", op_b, 381'd1);

        // adder_done high in LOAD_A is ignored
        adder_done = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_done_state", state_dbg, S_LOAD_A);
        chk("idle_done_start", start, 0);
        chk("idle_done_busy", busy, 0);
        send(32'h1111_1111);
        send(32'h2222_2222);
        in_if.in_valid = 1'b0;
        tick();
        chk("loada_done_state", state_dbg, S_LOAD_A);
        chk("loada_done_count", count_dbg, 2);
        chk("loada_done_start", start, 0);
        chk("loada_done_busy", busy, 1);
        adder_done = 1'b0;

        // Random valid gaps: only handshakes advance
        do_reset();
        for (int k = 0; k < 12; k++) begin
            wa[k] = 32'h0101_0101 * (k + 1);
            wb[k] = ~wa[k];
        end
        exp_a = pack(wa);
        exp_b = pack(wb);
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 2)) begin
                in_if.in_valid = 1'b0;
                in_if.in_data  = $urandom;
                tick();
            end
            send(k < 12 ? wa[k] : wb[k-12]);
            if (k == 6) chk("gap_count_a", count_dbg, 7);
            if (k == 15) chk("gap_count_b", count_dbg, 4);
        end
        in_if.in_valid = 1'b0;
        chk("gap_op_a", op_a, exp_a);
        chk("gap_op_b", op_b, exp_b);
        chk("gap_start", start, 1);
`ifdef OPERAND_PAD_CHECK_EN
        chk("gap_pad_err", pad_err, 1);
`endif
        held_a = op_a;
        held_b = op_b;
        tick();
        tick();
        adder_done = 1'b1;
        tick();
        adder_done = 1'b0;
        chk("gap_done_state", state_dbg, S_LOAD_A);
        chk("gap_done_op_a", held_a, exp_a);
        chk("gap_done_op_b", held_b, exp_b);
`ifdef OPERAND_PAD_CHECK_EN
        chk("gap_pad_clear", pad_err, 0);

        // Padding bits set in B word 11
        for (int k = 0; k < 12; k++) send(32'h0);
        for (int k = 0; k < 11; k++) send(32'h0);
        send(32'hE000_0000);
        in_if.in_valid = 1'b0;
        chk("pad_set", pad_err, 1);
        chk("pad_op_b", op_b, 0);
        chk("pad_start", start, 1);
        tick();
        adder_done = 1'b1;
        tick();
        adder_done = 1'b0;
        chk("pad_clear", pad_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
